// File: rtl/packet_rr_arbiter.sv
// Round-robin packet arbiter: N requesters share one registered output stage.
// Header MSB ("more") locks the channel to one requester until a closing packet.
module packet_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned HDR_W   = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          inPacket_tx_valid,
  output logic [NUM_REQ-1:0]          inPacket_tx_ready,
  input  logic [NUM_REQ*HDR_W-1:0]    inPacket_tx_header,
  input  logic [NUM_REQ*ADDR_W-1:0]   inPacket_tx_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   inPacket_tx_data,
  output logic                        outPacket_rx_valid,
  input  logic                        outPacket_rx_ready,
  output logic [HDR_W-1:0]            outPacket_rx_header,
  output logic [ADDR_W-1:0]           outPacket_rx_addr,
  output logic [DATA_W-1:0]           outPacket_rx_data,
  output logic [$clog2(NUM_REQ)-1:0]  outPacket_rx_src,
  output logic                        locked,
  output logic [15:0]                 pkt_count
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} stateT;

  stateT              state;
  logic [SRC_W-1:0]   lastGrant;
  logic [SRC_W-1:0]   lockOwner;
  logic [SRC_W-1:0]   grantIdx;
  logic [SRC_W-1:0]   cand;
  logic               grantValid;
  logic               slotFree;
  logic [HDR_W-1:0]   selHeader;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;

  assign slotFree = !outPacket_rx_valid || outPacket_rx_ready;

  // Grant selection: owner only while locked, otherwise rotate from lastGrant+1
  always_comb begin
    inPacket_tx_ready = '0;
    grantIdx          = '0;
    grantValid        = 1'b0;
    cand              = '0;
    if (rst_n && slotFree) begin
      if (state == LOCKED) begin
        if (inPacket_tx_valid[lockOwner]) begin
          grantValid = 1'b1;
          grantIdx   = lockOwner;
        end
      end else begin
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          cand = SRC_W'((32'(lastGrant) + k) % NUM_REQ);
          if (!grantValid && inPacket_tx_valid[cand]) begin
            grantValid = 1'b1;
            grantIdx   = cand;
          end
        end
      end
    end
    if (grantValid) inPacket_tx_ready[grantIdx] = 1'b1;
  end

  // Payload mux for the granted requester
  always_comb begin
    selHeader = '0;
    selAddr   = '0;
    selData   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == SRC_W'(i)) begin
        selHeader = inPacket_tx_header[i*HDR_W +: HDR_W];
        selAddr   = inPacket_tx_addr[i*ADDR_W +: ADDR_W];
        selData   = inPacket_tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      locked              <= 1'b0;
      lastGrant           <= SRC_W'(NUM_REQ - 1);
      lockOwner           <= '0;
      outPacket_rx_valid  <= 1'b0;
      outPacket_rx_header <= '0;
      outPacket_rx_addr   <= '0;
      outPacket_rx_data   <= '0;
      outPacket_rx_src    <= '0;
      pkt_count           <= '0;
    end else begin
      if (grantValid) begin
        outPacket_rx_valid  <= 1'b1;
        outPacket_rx_header <= selHeader;
        outPacket_rx_addr   <= selAddr;
        outPacket_rx_data   <= selData;
        outPacket_rx_src    <= grantIdx;
        lastGrant           <= grantIdx;
        if (state == IDLE) begin
          if (selHeader[HDR_W-1]) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            lockOwner <= grantIdx;
          end
        end else if (!selHeader[HDR_W-1]) begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      end else if (outPacket_rx_ready) begin
        outPacket_rx_valid <= 1'b0;
      end
      if (outPacket_rx_valid && outPacket_rx_ready) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Scoreboard bench for packet_rr_arbiter: a reference model predicts grants and
// queues expected packets, which are compared as the output stage drains.
module tb_packet_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned HW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    txValid;
  logic [N-1:0]    txReady;
  logic [N*HW-1:0] txHeader;
  logic [N*AW-1:0] txAddr;
  logic [N*DW-1:0] txData;
  logic            rxValid;
  logic            rxReady;
  logic [HW-1:0]   rxHeader;
  logic [AW-1:0]   rxAddr;
  logic [DW-1:0]   rxData;
  logic [1:0]      rxSrc;
  logic            locked;
  logic [15:0]     pktCount;

  logic [HW-1:0] hdr  [N];
  logic [AW-1:0] addr [N];
  logic [DW-1:0] data [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      txHeader[i*HW +: HW] = hdr[i];
      txAddr[i*AW +: AW]   = addr[i];
      txData[i*DW +: DW]   = data[i];
    end
  end

  packet_rr_arbiter #(.NUM_REQ(N), .HDR_W(HW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .inPacket_tx_valid   (txValid),
    .inPacket_tx_ready   (txReady),
    .inPacket_tx_header  (txHeader),
    .inPacket_tx_addr    (txAddr),
    .inPacket_tx_data    (txData),
    .outPacket_rx_valid  (rxValid),
    .outPacket_rx_ready  (rxReady),
    .outPacket_rx_header (rxHeader),
    .outPacket_rx_addr   (rxAddr),
    .outPacket_rx_data   (rxData),
    .outPacket_rx_src    (rxSrc),
    .locked              (locked),
    .pkt_count           (pktCount)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] hdr;
    logic [15:0] addr;
    logic [31:0] data;
  } pktT;

  pktT        sb [$];
  logic [1:0] obsSrc [$];

  logic        mOutValid;
  logic        mLocked;
  int          mOwner;
  int          mLast;
  logic [15:0] mCount;

  int errCnt = 0;
  int chkCnt = 0;
  logic         seenLocked;
  logic [N-1:0] seenReady;

  int expT1 [5] = '{0, 1, 2, 3, 0};
  int expT2 [5] = '{1, 2, 2, 2, 3};

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    mOutValid = 1'b0;
    mLocked   = 1'b0;
    mOwner    = 0;
    mLast     = N - 1;
    mCount    = '0;
    sb.delete();
  endtask

  function automatic int modelGrant();
    int idx;
    if (!(!mOutValid || rxReady)) return -1;
    if (mLocked) return txValid[mOwner] ? mOwner : -1;
    for (int k = 1; k <= N; k++) begin
      idx = (mLast + k) % N;
      if (txValid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: compare outputs at negedge, advance the model at posedge
  task automatic step();
    int           g;
    logic [N-1:0] expReady;
    pktT          p;
    logic         wasValid;
    @(negedge clk);
    checkEq("out_valid", 64'(rxValid), 64'(mOutValid));
    checkEq("locked", 64'(locked), 64'(mLocked));
    checkEq("pkt_count", 64'(pktCount), 64'(mCount));
    seenLocked = locked;
    seenReady  = txReady;
    if (mOutValid) begin
      if (sb.size() == 0) checkEq("sb_underflow", 64'(sb.size()), 64'(1));
      else begin
        p = sb[0];
        checkEq("out_src", 64'(rxSrc), 64'(p.src));
        checkEq("out_header", 64'(rxHeader), 64'(p.hdr));
        checkEq("out_addr", 64'(rxAddr), 64'(p.addr));
        checkEq("out_data", 64'(rxData), 64'(p.data));
        if (rxReady) begin
          obsSrc.push_back(rxSrc);
          void'(sb.pop_front());
        end
      end
    end
    g = modelGrant();
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkEq("tx_ready", 64'(txReady), 64'(expReady));
    @(posedge clk);
    wasValid = mOutValid;
    if (g >= 0) begin
      p.src  = 2'(g);
      p.hdr  = hdr[g];
      p.addr = addr[g];
      p.data = data[g];
      sb.push_back(p);
      mLast = g;
      if (!mLocked && hdr[g][HW-1]) begin
        mLocked = 1'b1;
        mOwner  = g;
      end else if (mLocked && !hdr[g][HW-1]) begin
        mLocked = 1'b0;
      end
    end
    if (wasValid && rxReady) mCount = mCount + 16'd1;
    mOutValid = (g >= 0) || (wasValid && !rxReady);
    #1;
  endtask

  task automatic checkSrcList(input string tag, input int exp [5]);
    checkEq({tag, "_len"}, 64'(obsSrc.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < obsSrc.size()) checkEq($sformatf("%s_%0d", tag, i), 64'(obsSrc[i]), 64'(exp[i]));
    end
  endtask

  initial begin
    int iter;
    rst_n   = 1'b0;
    rxReady = 1'b0;
    txValid = '1;
    for (int i = 0; i < N; i++) begin
      hdr[i]  = 16'h0100 + 16'(i);
      addr[i] = 16'hA000 + 16'(i);
      data[i] = 32'hD000_0000 + 32'(i);
    end
    resetModel();

    // Reset values, readies held low despite valid requesters
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_valid", 64'(rxValid), 64'h0);
    checkEq("rst_locked", 64'(locked), 64'h0);
    checkEq("rst_count", 64'(pktCount), 64'h0);
    checkEq("rst_header", 64'(rxHeader), 64'h0);
    checkEq("rst_addr", 64'(rxAddr), 64'h0);
    checkEq("rst_data", 64'(rxData), 64'h0);
    checkEq("rst_src", 64'(rxSrc), 64'h0);
    checkEq("rst_ready", 64'(txReady), 64'h0);
    @(negedge clk);
    txValid = '0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Plain round robin across all four requesters
    rxReady = 1'b1;
    txValid = 4'b1111;
    obsSrc.delete();
    repeat (5) step();
    txValid = '0;
    repeat (2) step();
    checkSrcList("rr_order", expT1);
    checkEq("rr_count5", 64'(pktCount), 64'd5);

    // Locked burst from requester 2 with others contending
    obsSrc.delete();
    txValid = 4'b0010;
    hdr[1]  = 16'h0101;
    step();
    txValid = 4'b1111;
    hdr[2]  = 16'h8001;
    step();
    checkEq("lk_ready_a", 64'(seenReady), 64'b0100);
    checkEq("lk_locked_a", 64'(seenLocked), 64'h0);
    hdr[2] = 16'h8002;
    step();
    checkEq("lk_ready_b", 64'(seenReady), 64'b0100);
    checkEq("lk_locked_b", 64'(seenLocked), 64'h1);
    hdr[2] = 16'h0003;
    step();
    checkEq("lk_ready_c", 64'(seenReady), 64'b0100);
    checkEq("lk_locked_c", 64'(seenLocked), 64'h1);
    hdr[2] = 16'h0004;
    step();
    checkEq("lk_ready_d", 64'(seenReady), 64'b1000);
    checkEq("lk_locked_d", 64'(seenLocked), 64'h0);
    txValid = '0;
    repeat (2) step();
    checkSrcList("lk_order", expT2);

    // Backpressure: output held stable, no readies until sink returns
    rxReady = 1'b0;
    txValid = 4'b0010;
    addr[1] = 16'h1234;
    data[1] = 32'hDEAD_BEEF;
    step();
    checkEq("bp_first_ready", 64'(seenReady), 64'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      checkEq("bp_ready", 64'(seenReady), 64'h0);
      checkEq("bp_addr", 64'(rxAddr), 64'h1234);
      checkEq("bp_data", 64'(rxData), 64'hDEAD_BEEF);
      checkEq("bp_src", 64'(rxSrc), 64'h1);
    end
    rxReady = 1'b1;
    step();
    checkEq("bp_resume_ready", 64'(seenReady), 64'b0010);
    txValid = '0;
    repeat (2) step();

    // Lock owner goes quiet; the other requester must be starved meanwhile
    txValid = 4'b0011;
    hdr[0]  = 16'h8005;
    hdr[1]  = 16'h0011;
    step();
    checkEq("own_grant", 64'(seenReady), 64'b0001);
    txValid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      checkEq("own_starve", 64'(seenReady), 64'h0);
    end
    checkEq("own_locked", 64'(locked), 64'h1);
    txValid = 4'b0011;
    hdr[0]  = 16'h0010;
    step();
    checkEq("own_close", 64'(seenReady), 64'b0001);
    txValid = 4'b0010;
    step();
    checkEq("own_next", 64'(seenReady), 64'b0010);
    checkEq("own_unlocked", 64'(locked), 64'h0);
    txValid = '0;
    repeat (2) step();

    // Asynchronous reset while locked with a held output packet
    rxReady = 1'b0;
    txValid = 4'b0011;
    hdr[0]  = 16'h8006;
    step();
    step();
    checkEq("ar_pre_valid", 64'(rxValid), 64'h1);
    checkEq("ar_pre_locked", 64'(locked), 64'h1);
    rst_n = 1'b0;
    #1;
    checkEq("ar_valid", 64'(rxValid), 64'h0);
    checkEq("ar_locked", 64'(locked), 64'h0);
    checkEq("ar_ready", 64'(txReady), 64'h0);
    checkEq("ar_count", 64'(pktCount), 64'h0);
    resetModel();
    txValid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rxReady = 1'b1;
    txValid = 4'b1111;
    hdr[0]  = 16'h0020;
    step();
    checkEq("ar_first_grant", 64'(seenReady), 64'b0001);
    txValid = '0;
    repeat (2) step();

    // Stream until the delivered-packet counter wraps
    txValid = 4'b1111;
    iter = 0;
    while (mCount != 16'hFFFF && iter < 70000) begin
      step();
      iter++;
    end
    checkEq("wrap_budget", 64'(mCount), 64'hFFFF);
    checkEq("wrap_ffff", 64'(pktCount), 64'hFFFF);
    step();
    checkEq("wrap_zero", 64'(pktCount), 64'h0);
    txValid = '0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
